tinker_mem_arbiter: RTL and testbench
=====================================

Name: tinker_mem_arbiter

Overview:
Shares the single byte-wide memory array between two requesters: the instruction-fetch unit (32-bit reads) and the load/store unit (64-bit reads and writes).
Accepts one request at a time through a req/gnt handshake and serialises it into byte beats on the memory port. Reassembles read data big-endian and returns it with a one-cycle done pulse.
Sits between tinker_core's fetch/control logic and the memory byte array. The FSM stalls on the done pulses.

Parameters:
ADDR_W, 32, byte-address width of all address ports.
IF_BEATS, 4, bytes per fetch access.
LS_BEATS, 8, bytes per load/store access.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
if_req  input  1  fetch request; held high with if_addr stable until if_gnt
if_addr  input  ADDR_W  fetch byte address (no alignment required)
if_gnt  output  1  one-cycle pulse: fetch request accepted this cycle
if_done  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  32  fetched instruction, big-endian
ls_req  input  1  load/store request; held with ls_addr/ls_we/ls_wdata until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  data byte address
ls_wdata  input  64  store data, big-endian (bits 63:56 to lowest address)
ls_gnt  output  1  one-cycle pulse: load/store accepted
ls_done  output  1  one-cycle pulse: load data valid or store complete
ls_rdata  output  64  loaded data, big-endian
mem_en  output  1  memory access this cycle
mem_we  output  1  byte write this cycle (only with mem_en)
mem_addr  output  ADDR_W  byte address
mem_wdata  output  8  write byte
mem_rdata  input  8  read byte; valid the cycle after a read issue (1-cycle latency)

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; all gnt/done/mem_en/mem_we=0; mem_addr=0, mem_wdata=0; if_rdata=0, ls_rdata=0; last_grant=IF. Reset mid-access aborts it. No done pulse is issued, partially written bytes stay written, and the requester must re-request.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if any req is high, the grant is combinational in the same cycle. Pulse the winner's gnt, latch its addr/we/wdata/owner, clear beat counter k. Next state is ISSUE.
- Arbitration when both are high: round-robin. The grant goes to the requester opposite last_grant. Reset value of last_grant=IF, so the LSU wins the first tie. last_grant updates on every grant.
- ISSUE (cycle T+1+k for grant at T): mem_en=1, mem_addr=base+k. The sum is computed ADDR_W-bit and wraps modulo 2^ADDR_W.
  - Store: mem_we=1, mem_wdata=ls_wdata[63-8k -: 8].
  - k increments each cycle. After the last beat (k=N-1), go to DRAIN for reads and DONE for stores.
- Read capture: the byte issued in cycle t is registered from mem_rdata at the end of t+1, into the big-endian slot for beat k-1.
- DRAIN (one cycle): mem_en=0. Captures the final byte. Next state is DONE.
- DONE (one cycle): pulse the owner's done. rdata is registered and held stable until that owner's next done. Next state is IDLE.
  - Read latency, grant to done: N+2 cycles (fetch 6, load 10).
  - Store latency: N+1 cycles (9).
- No new grant is issued outside IDLE. Requests arriving during ISSUE/DRAIN/DONE wait; a req high in DONE is granted in the following IDLE cycle.
- gnt, done and mem_we are never asserted to both requesters in the same cycle.
- The requester changing addr or dropping req before gnt is a protocol violation; the bench asserts against it.
- Dropping req after gnt has no effect on the in-flight access.
- if_rdata is not disturbed by LS accesses, and ls_rdata is not disturbed by IF accesses.

Decomposition:
- Shared package tinker_mem_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, DRAIN, DONE};
  - typedef enum owner_t {OWN_IF, OWN_LS};
  - constants IF_BEATS_C=4, LS_BEATS_C=8.
- One natural sub-module, tinker_rr_arb2: a combinational two-way round-robin pick plus the registered last_grant.
- Beat sequencing and data assembly stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both reqs high → no gnt, mem_en=0, all outputs 0. Release → ls_gnt pulses on the first cycle.
- Fetch: preload bytes 0x2000..0x2003 = 12 34 56 78; if_req at 0x2000 → if_gnt at T, mem_addr 0x2000..0x2003 on T+1..T+4, if_done at T+6 with if_rdata=0x12345678.
- Store then load: ls_we=1, addr 0x80000-8, wdata 0x0123456789ABCDEF → 8 write beats, ls_done at T+9; memory byte 0x7FFF8=0x01 and byte 0x7FFFF=0xEF. Load from the same address → ls_rdata=0x0123456789ABCDEF at T+10.
- Contention: if_req and ls_req held high continuously → grants alternate LS, IF, LS, IF. Each done comes before the next gnt, and gnts are never simultaneous.
- Wrap: fetch at addr 0xFFFFFFFE → mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Mid-access reset: assert reset at load beat 3 → no ls_done, state IDLE next cycle. A re-issued load completes normally with correct data.

Source files
------------

// File: rtl/tinker_mem_pkg.sv
// tinker_mem_pkg: shared types and beat counts for the memory arbiter
package tinker_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;
  localparam int IF_BEATS_C = 4;
  localparam int LS_BEATS_C = 8;
endpackage

// File: rtl/tinker_rr_arb2.sv
// tinker_rr_arb2: two-way round-robin pick with registered last grant
module tinker_rr_arb2
  import tinker_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_if,
  input  logic req_ls,
  output logic gnt_if,
  output logic gnt_ls
);
  owner_t last_q, last_d;
  always_comb begin
    gnt_ls = en && req_ls && (!req_if || last_q == OWN_IF);
    gnt_if = en && req_if && !gnt_ls;
    last_d = gnt_ls ? OWN_LS : gnt_if ? OWN_IF : last_q;
  end
  always_ff @(posedge clk)
    if (!reset) last_q <= OWN_IF;
    else last_q <= last_d;
endmodule

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: serialises fetch and load/store requests onto a byte-wide memory port
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int IF_BEATS = IF_BEATS_C,
  parameter int LS_BEATS = LS_BEATS_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [63:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [63:0]       ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  arb_state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic we_q, we_d, rd_q, rd_d;
  logic [3:0] k_q, k_d, last_k;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [63:0] wdata_q, wdata_d, asm_q, asm_d, ls_rdata_q, ls_rdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [7:0] wbyte;
  tinker_rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .en(reset && state_q == IDLE),
    .req_if(if_req),
    .req_ls(ls_req),
    .gnt_if(if_gnt),
    .gnt_ls(ls_gnt)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    k_d = k_q;
    base_d = base_q;
    wdata_d = wdata_q;
    asm_d = asm_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    wbyte = '0;
    rd_d = state_q == ISSUE && !we_q;
    last_k = owner_q == OWN_LS ? 4'(LS_BEATS - 1) : 4'(IF_BEATS - 1);
    for (int i = 0; i < 8; i++) begin
      if (rd_q && k_q == 4'(i + 1)) asm_d[63 - 8*i -: 8] = mem_rdata;
      if (k_q[2:0] == 3'(i)) wbyte = wdata_q[63 - 8*i -: 8];
    end
    unique case (state_q)
      IDLE: if (if_gnt || ls_gnt) begin
        owner_d = ls_gnt ? OWN_LS : OWN_IF;
        base_d = ls_gnt ? ls_addr : if_addr;
        we_d = ls_gnt && ls_we;
        wdata_d = ls_wdata;
        k_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        k_d = k_q + 4'd1;
        if (k_q == last_k) state_d = we_q ? DONE : DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
        if (owner_q == OWN_LS) ls_rdata_d = asm_d;
        else if_rdata_d = asm_d[63:32];
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q <= 1'b0;
      rd_q <= 1'b0;
      k_q <= '0;
      base_q <= '0;
      wdata_q <= '0;
      asm_q <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      rd_q <= rd_d;
      k_q <= k_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      asm_q <= asm_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  assign mem_en = state_q == ISSUE;
  assign mem_we = mem_en && we_q;
  assign mem_addr = mem_en ? base_q + ADDR_W'(k_q) : '0;
  assign mem_wdata = mem_we ? wbyte : '0;
  assign if_done = state_q == DONE && owner_q == OWN_IF;
  assign ls_done = state_q == DONE && owner_q == OWN_LS;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: directed self-checking bench for the memory arbiter
module tb_tinker_mem_arbiter;
  logic clk = 0, reset = 0, if_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] if_addr = '0, ls_addr = '0;
  logic [63:0] ls_wdata = '0;
  logic if_gnt, if_done, ls_gnt, ls_done, mem_en, mem_we;
  logic [31:0] if_rdata, mem_addr;
  logic [63:0] ls_rdata;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic pl_en = 0;
  logic [15:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  logic [7:0] mem [0:65535] = '{default: 8'h00};
  int checks = 0, failures = 0;
  logic p_ok = 0, p_if = 0, p_ls = 0, p_lswe = 0;
  logic [31:0] p_ifa = '0, p_lsa = '0;
  tinker_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (mem_en && mem_we) mem[mem_addr[15:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[15:0]];
  end
  always @(posedge clk) begin
    if (p_ok && reset && p_if && (!if_req || if_addr !== p_ifa)) $error("protocol: fetch request changed before grant");
    if (p_ok && reset && p_ls && (!ls_req || ls_addr !== p_lsa || ls_we !== p_lswe)) $error("protocol: load/store request changed before grant");
    p_ok <= reset;
    p_if <= if_req && !if_gnt;
    p_ls <= ls_req && !ls_gnt;
    p_ifa <= if_addr;
    p_lsa <= ls_addr;
    p_lswe <= ls_we;
  end
  function automatic logic sig(input int w);
    return w == 0 ? if_gnt : w == 1 ? ls_gnt : w == 2 ? if_done : ls_done;
  endfunction
  task automatic preload(input logic [15:0] a0, input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pl_en = 1;
      pl_a = a0 + 16'(i);
      pl_d = d[63 - 8*i -: 8];
    end
    @(negedge clk);
    pl_en = 0;
  endtask
  task automatic wait_for(input int which, input bit dif, input bit dls, output int n);
    n = -1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (dif) if_req = 0;
        if (dls) ls_req = 0;
      end
      #1;
      if (sig(which)) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic access(input bit ls, input bit we, input logic [31:0] addr, input logic [63:0] wd,
                        output int g, output int d, output int nb, output int nw,
                        output logic [255:0] a, output logic [63:0] wb, output bit bad);
    g = -1; d = -1; nb = 0; nw = 0; a = '0; wb = '0; bad = 0;
    @(negedge clk);
    if (ls) begin
      ls_req = 1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (ls ? ls_gnt : if_gnt) begin
        g = i;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (g < 0) return;
    bad = if_gnt && ls_gnt;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (ls) ls_req = 0;
        else if_req = 0;
      end
      #1;
      if (if_gnt || ls_gnt || (ls ? if_done : ls_done)) bad = 1;
      if (mem_en && nb < 8) begin
        a[nb*32 +: 32] = mem_addr;
        wb[63 - nb*8 -: 8] = mem_wdata;
        nw += int'(mem_we);
        nb++;
      end
      if (ls ? ls_done : if_done) begin
        d = i;
        break;
      end
    end
  endtask
  task automatic test_reset();
    int n;
    if_req = 1; if_addr = 32'h2000; ls_req = 1; ls_we = 0; ls_addr = 32'h3000; reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({if_gnt, ls_gnt, if_done, ls_done, mem_en, mem_we} !== 6'b0 || mem_addr !== 32'h0 ||
          mem_wdata !== 8'h0 || if_rdata !== 32'h0 || ls_rdata !== 64'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: gnt=%b%b done=%b%b en=%b we=%b addr=%h wd=%h ifr=%h lsr=%h want all zero",
                 i, if_gnt, ls_gnt, if_done, ls_done, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, ls_rdata);
      end
    end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_tie if_gnt/ls_gnt got=%b%b want=01", if_gnt, ls_gnt);
    end
    wait_for(3, 0, 1, n);
    checks++;
    if (n != 10 || ls_rdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_first_load latency got=%0d want=10 ls_rdata got=%h want=0", n, ls_rdata);
    end
    wait_for(0, 0, 0, n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL reset_pending_if grant delay got=%0d want=1", n);
    end
    wait_for(2, 1, 0, n);
    checks++;
    if (n != 6 || if_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL reset_pending_if done latency got=%0d want=6 rdata got=%h want=12345678", n, if_rdata);
    end
  endtask
  task automatic test_fetch();
    int g, d, nb, nw;
    logic [255:0] a;
    logic [63:0] wb;
    bit bad;
    access(0, 0, 32'h2000, 64'h0, g, d, nb, nw, a, wb, bad);
    checks++;
    if (g != 0 || d != 6 || nb != 4 || nw != 0 || bad) begin
      failures++;
      $display("FAIL fetch_timing g=%0d d=%0d beats=%0d writes=%0d bad=%0d want 0/6/4/0/0", g, d, nb, nw, bad);
    end
    checks++;
    if (a[127:0] !== {32'h2003, 32'h2002, 32'h2001, 32'h2000}) begin
      failures++;
      $display("FAIL fetch_addrs got=%h want=00002003000020020000200100002000", a[127:0]);
    end
    checks++;
    if (if_rdata !== 32'h12345678 || ls_rdata !== 64'h0) begin
      failures++;
      $display("FAIL fetch_rdata if_rdata=%h want=12345678 ls_rdata=%h want=0", if_rdata, ls_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (if_done !== 1'b0 || if_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL fetch_hold if_done=%b want=0 if_rdata=%h want=12345678", if_done, if_rdata);
    end
  endtask
  task automatic test_store_load();
    int g, d, nb, nw;
    logic [255:0] a;
    logic [63:0] wb;
    bit bad;
    access(1, 1, 32'h7FFF8, 64'h0123456789ABCDEF, g, d, nb, nw, a, wb, bad);
    checks++;
    if (g != 0 || d != 9 || nb != 8 || nw != 8 || bad) begin
      failures++;
      $display("FAIL store_timing g=%0d d=%0d beats=%0d writes=%0d bad=%0d want 0/9/8/8/0", g, d, nb, nw, bad);
    end
    checks++;
    if (wb !== 64'h0123456789ABCDEF || a[31:0] !== 32'h7FFF8 || a[255:224] !== 32'h7FFFF) begin
      failures++;
      $display("FAIL store_beats wdata=%h want=0123456789abcdef first=%h want=7fff8 last=%h want=7ffff", wb, a[31:0], a[255:224]);
    end
    checks++;
    if (mem[16'hFFF8] !== 8'h01 || mem[16'hFFFF] !== 8'hEF) begin
      failures++;
      $display("FAIL store_mem byte7fff8=%h want=01 byte7ffff=%h want=ef", mem[16'hFFF8], mem[16'hFFFF]);
    end
    access(1, 0, 32'h7FFF8, 64'h0, g, d, nb, nw, a, wb, bad);
    checks++;
    if (g != 0 || d != 10 || nb != 8 || nw != 0 || bad) begin
      failures++;
      $display("FAIL load_timing g=%0d d=%0d beats=%0d writes=%0d bad=%0d want 0/10/8/0/0", g, d, nb, nw, bad);
    end
    checks++;
    if (ls_rdata !== 64'h0123456789ABCDEF || if_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL load_rdata ls_rdata=%h want=0123456789abcdef if_rdata=%h want=12345678", ls_rdata, if_rdata);
    end
  endtask
  task automatic test_back_to_back();
    int t[5];
    bit seq[5];
    int et[5] = '{0, 11, 18, 29, 36};
    bit es[5] = '{1, 0, 1, 0, 1};
    int ng = 0;
    bit both = 0, nodone = 0, dseen = 0;
    for (int i = 0; i < 5; i++) begin
      t[i] = -1;
      seq[i] = 0;
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1; if_req = 1; if_addr = 32'h2000; ls_req = 1; ls_we = 0; ls_addr = 32'h7FFF8;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (if_gnt && ls_gnt) both = 1;
      if (if_gnt || ls_gnt) begin
        if (ng > 0 && !dseen) nodone = 1;
        if (ng < 5) begin
          t[ng] = c;
          seq[ng] = ls_gnt;
        end
        ng++;
        dseen = 0;
      end
      if (if_done || ls_done) dseen = 1;
      @(negedge clk);
      if (ng >= 4) if_req = 0;
      if (ng >= 5) ls_req = 0;
      #1;
    end
    checks++;
    if (ng != 5 || both || nodone) begin
      failures++;
      $display("FAIL contention_summary grants=%0d want=5 simultaneous=%0d want=0 gnt_before_done=%0d want=0", ng, both, nodone);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (t[i] != et[i] || seq[i] != es[i]) begin
        failures++;
        $display("FAIL contention_grant%0d cycle=%0d owner_ls=%0d want cycle=%0d owner_ls=%0d", i, t[i], seq[i], et[i], es[i]);
      end
    end
  endtask
  task automatic test_wrap();
    int g, d, nb, nw;
    logic [255:0] a;
    logic [63:0] wb;
    bit bad;
    preload(16'hFFFE, 64'hAABBCCDD_00000000, 4);
    access(0, 0, 32'hFFFFFFFE, 64'h0, g, d, nb, nw, a, wb, bad);
    checks++;
    if (a[127:0] !== {32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE} || nb != 4) begin
      failures++;
      $display("FAIL wrap_addrs got=%h beats=%0d want=0000000100000000fffffffffffffffe beats=4", a[127:0], nb);
    end
    checks++;
    if (d != 6 || if_rdata !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL wrap_rdata d=%0d want=6 if_rdata=%h want=aabbccdd", d, if_rdata);
    end
  endtask
  task automatic test_mid_reset();
    int g, d, nb, nw;
    logic [255:0] a;
    logic [63:0] wb;
    bit bad;
    bit seen = 0;
    preload(16'h4000, 64'h1122334455667788, 8);
    @(negedge clk);
    ls_req = 1; ls_we = 0; ls_addr = 32'h4000;
    #1;
    checks++;
    if (ls_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midreset_grant ls_gnt=%b want=1", ls_gnt);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) ls_req = 0;
      #1;
    end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h4003) begin
      failures++;
      $display("FAIL midreset_beat3 mem_en=%b addr=%h want en=1 addr=00004003", mem_en, mem_addr);
    end
    reset = 0;
    @(negedge clk);
    reset = 1; if_req = 1; if_addr = 32'h2000;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || ls_rdata !== 64'h0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_idle if_gnt=%b want=1 ls_rdata=%h if_rdata=%h want zero", if_gnt, ls_rdata, if_rdata);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) if_req = 0;
      #1;
      if (ls_done) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_done ls_done seen=1 want=0");
    end
    access(1, 0, 32'h4000, 64'h0, g, d, nb, nw, a, wb, bad);
    checks++;
    if (g != 0 || d != 10 || ls_rdata !== 64'h1122334455667788 || bad) begin
      failures++;
      $display("FAIL midreset_reload g=%0d d=%0d ls_rdata=%h bad=%0d want 0/10/1122334455667788/0", g, d, ls_rdata, bad);
    end
  endtask
  initial begin
    preload(16'h2000, 64'h12345678_00000000, 4);
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
